// File: rtl/dist_pkg.sv
// Shared types and defaults for the minimum-distance tracker that sits after the distance calculator.
package dist_pkg;

  localparam int DIST_W_DEF = 38;
  localparam int ID_W_DEF   = 16;

  typedef logic [DIST_W_DEF-1:0] dist_t;
  typedef logic [ID_W_DEF-1:0]   cand_id_t;

  localparam dist_t DIST_MAX = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/dist_min_tracker_if.sv
// Bus between the search controller, the distance calculator and the minimum tracker.
interface dist_min_tracker_if #(
  parameter int DIST_W = dist_pkg::DIST_W_DEF,
  parameter int ID_W   = dist_pkg::ID_W_DEF
);

  logic              search_start;
  logic [ID_W-1:0]   n_cand;
  logic [DIST_W-1:0] thresh;
  logic              dist_valid;
  logic [DIST_W-1:0] dist2;
  logic [ID_W-1:0]   cand_id;

  logic              busy;
  logic              done;
  logic              best_valid;
  logic [DIST_W-1:0] best_dist;
  logic [ID_W-1:0]   best_id;
  logic [ID_W-1:0]   cand_count;
  logic              hit;

  modport master (
    output search_start, n_cand, thresh, dist_valid, dist2, cand_id,
    input  busy, done, best_valid, best_dist, best_id, cand_count, hit
  );

  modport slave (
    input  search_start, n_cand, thresh, dist_valid, dist2, cand_id,
    output busy, done, best_valid, best_dist, best_id, cand_count, hit
  );

endinterface

// File: rtl/dist_min_cmp.sv
// Combinational compare of an incoming squared distance against the running best and the threshold.
module dist_min_cmp #(
  parameter int DIST_W = dist_pkg::DIST_W_DEF
) (
  input  logic [DIST_W-1:0] dist2_i,
  input  logic [DIST_W-1:0] best_dist_i,
  input  logic              best_valid_i,
  input  logic [DIST_W-1:0] thresh_i,
  output logic              take_new_o,
  output logic              within_thresh_o
);

  // Strict less-than keeps the earlier candidate on ties; an empty best always accepts.
  assign take_new_o      = !best_valid_i || (dist2_i < best_dist_i);
  assign within_thresh_o = (dist2_i <= thresh_i);

endmodule

// File: rtl/dist_min_tracker.sv
// Tracks the minimum squared distance and its candidate id over one search.
// Optional early stop on a threshold hit: define DIST_MIN_EARLY_STOP_EN.
module dist_min_tracker
  import dist_pkg::*;
#(
  parameter int DIST_W = DIST_W_DEF,
  parameter int ID_W   = ID_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  dist_min_tracker_if.slave   bus
);

  state_e            state_q;
  logic              busy_q;
  logic              done_q;
  logic              best_valid_q;
  logic [DIST_W-1:0] best_dist_q;
  logic [ID_W-1:0]   best_id_q;
  logic [ID_W-1:0]   cand_count_q;
  logic              hit_q;
  logic [ID_W-1:0]   n_cand_q;
  logic [DIST_W-1:0] thresh_q;

  logic [ID_W-1:0]   cand_count_d;
  logic              take_new;
  logic              within_thresh;
  logic              sample_fire;
  logic              last_sample_d;

  dist_min_cmp #(
    .DIST_W (DIST_W)
  ) u_cmp (
    .dist2_i         (bus.dist2),
    .best_dist_i     (best_dist_q),
    .best_valid_i    (best_valid_q),
    .thresh_i        (thresh_q),
    .take_new_o      (take_new),
    .within_thresh_o (within_thresh)
  );

  assign cand_count_d = cand_count_q + 1'b1;
  // A start in the same cycle wins over the sample, so the sample is dropped.
  assign sample_fire  = (state_q == SEARCH) && bus.dist_valid && !bus.search_start;

`ifdef DIST_MIN_EARLY_STOP_EN
  assign last_sample_d = (cand_count_d == n_cand_q) || within_thresh;
`else
  assign last_sample_d = (cand_count_d == n_cand_q);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      best_valid_q <= 1'b0;
      best_dist_q  <= {DIST_W{1'b1}};
      best_id_q    <= '0;
      cand_count_q <= '0;
      hit_q        <= 1'b0;
      n_cand_q     <= '0;
      thresh_q     <= '0;
    end else if (bus.search_start) begin
      n_cand_q     <= bus.n_cand;
      thresh_q     <= bus.thresh;
      best_valid_q <= 1'b0;
      best_dist_q  <= {DIST_W{1'b1}};
      best_id_q    <= '0;
      cand_count_q <= '0;
      hit_q        <= 1'b0;
      if (bus.n_cand == '0) begin
        state_q <= DONE;
        busy_q  <= 1'b0;
        done_q  <= 1'b1;
      end else begin
        state_q <= SEARCH;
        busy_q  <= 1'b1;
        done_q  <= 1'b0;
      end
    end else if (sample_fire) begin
      cand_count_q <= cand_count_d;
      if (take_new) begin
        best_dist_q  <= bus.dist2;
        best_id_q    <= bus.cand_id;
        best_valid_q <= 1'b1;
      end
      if (within_thresh) begin
        hit_q <= 1'b1;
      end
      if (last_sample_d) begin
        state_q <= DONE;
        busy_q  <= 1'b0;
        done_q  <= 1'b1;
      end
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.best_valid = best_valid_q;
  assign bus.best_dist  = best_dist_q;
  assign bus.best_id    = best_id_q;
  assign bus.cand_count = cand_count_q;
  assign bus.hit        = hit_q;

endmodule

// File: tb/tb_dist_min_tracker.sv
// Bench for dist_min_tracker: list-based reference model checked every cycle plus directed literal checks.
module tb_dist_min_tracker;

  localparam int DW = 38;
  localparam int IW = 16;
  localparam logic [DW-1:0] ALL1 = {DW{1'b1}};

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dist_min_tracker_if #(.DIST_W(DW), .ID_W(IW)) bus ();

  dist_min_tracker #(.DIST_W(DW), .ID_W(IW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: samples accepted in the current search, plus phase flags.
  logic [DW-1:0] acc_d[$];
  logic [IW-1:0] acc_id[$];
  bit            m_busy, m_done;
  int            m_ncand;
  logic [DW-1:0] m_thresh;

  always @(posedge clk) begin
    if (reset) begin
      acc_d.delete(); acc_id.delete();
      m_busy = 0; m_done = 0; m_ncand = 0; m_thresh = '0;
    end else if (bus.search_start) begin
      acc_d.delete(); acc_id.delete();
      m_ncand  = int'(bus.n_cand);
      m_thresh = bus.thresh;
      m_busy   = (bus.n_cand != 0);
      m_done   = (bus.n_cand == 0);
    end else if (m_busy && bus.dist_valid) begin
      acc_d.push_back(bus.dist2);
      acc_id.push_back(bus.cand_id);
      if (acc_d.size() == m_ncand) begin
        m_busy = 0; m_done = 1;
      end
`ifdef DIST_MIN_EARLY_STOP_EN
      if (bus.dist2 <= m_thresh) begin
        m_busy = 0; m_done = 1;
      end
`endif
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [DW-1:0] e_best;
      logic [IW-1:0] e_id;
      bit            e_hit;
      e_best = ALL1; e_id = '0; e_hit = 0;
      for (int i = 0; i < acc_d.size(); i++) begin
        if (i == 0 || acc_d[i] < e_best) begin
          e_best = acc_d[i];
          e_id   = acc_id[i];
        end
        if (acc_d[i] <= m_thresh) e_hit = 1;
      end
      chk("m_busy",       64'(bus.busy),       64'(m_busy));
      chk("m_done",       64'(bus.done),       64'(m_done));
      chk("m_best_valid", 64'(bus.best_valid), 64'(acc_d.size() > 0));
      chk("m_best_dist",  64'(bus.best_dist),  64'(e_best));
      chk("m_best_id",    64'(bus.best_id),    64'(e_id));
      chk("m_cand_count", 64'(bus.cand_count), 64'(acc_d.size()));
      chk("m_hit",        64'(bus.hit),        64'(e_hit));
    end
  end

  task automatic quiet();
    bus.search_start = 1'b0;
    bus.dist_valid   = 1'b0;
  endtask

  task automatic start(input int n, input logic [DW-1:0] t);
    bus.search_start = 1'b1;
    bus.dist_valid   = 1'b0;
    bus.n_cand       = IW'(n);
    bus.thresh       = t;
    @(negedge clk);
    quiet();
  endtask

  task automatic feed(input logic [DW-1:0] d, input int id);
    bus.search_start = 1'b0;
    bus.dist_valid   = 1'b1;
    bus.dist2        = d;
    bus.cand_id      = IW'(id);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    quiet();
    bus.n_cand = '0; bus.thresh = '0; bus.dist2 = '0; bus.cand_id = '0;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_busy",  64'(bus.busy), 64'd0);
    chk("rst_done",  64'(bus.done), 64'd0);
    chk("rst_best",  64'(bus.best_dist), 64'(ALL1));
    chk("rst_count", 64'(bus.cand_count), 64'd0);
    reset = 1'b0;

    // Basic minimum search
    start(3, 0);
    chk("t1_busy", 64'(bus.busy), 64'd1);
    feed(500, 7); feed(200, 9); feed(300, 4); quiet();
    chk("t1_best",  64'(bus.best_dist), 64'd200);
    chk("t1_id",    64'(bus.best_id), 64'd9);
    chk("t1_count", 64'(bus.cand_count), 64'd3);
    chk("t1_done",  64'(bus.done), 64'd1);
    chk("t1_hit",   64'(bus.hit), 64'd0);
    feed(1, 1); quiet();
    chk("t1_hold",  64'(bus.best_dist), 64'd200);
    @(negedge clk);

    // Tie keeps earlier candidate
    start(2, 0);
    feed(100, 1); feed(100, 2); quiet();
    chk("t2_id",   64'(bus.best_id), 64'd1);
    chk("t2_done", 64'(bus.done), 64'd1);

    // Zero candidates
    start(0, 0);
    chk("t3_done",  64'(bus.done), 64'd1);
    chk("t3_valid", 64'(bus.best_valid), 64'd0);
    chk("t3_best",  64'(bus.best_dist), 64'(ALL1));

    // Start coincident with a sample discards it
    start(3, 0);
    feed(10, 3);
    bus.search_start = 1'b1; bus.n_cand = 16'd3; bus.dist_valid = 1'b1;
    bus.dist2 = 38'd5; bus.cand_id = 16'd8;
    @(negedge clk); quiet();
    chk("t4_count", 64'(bus.cand_count), 64'd0);
    chk("t4_valid", 64'(bus.best_valid), 64'd0);
    chk("t4_busy",  64'(bus.busy), 64'd1);
    feed(40, 2); quiet(); @(negedge clk);

    // Threshold, with and without early stop
    start(4, 150);
    feed(400, 1); feed(120, 2); quiet();
    chk("t5_hit1",  64'(bus.hit), 64'd1);
    chk("t5_best1", 64'(bus.best_dist), 64'd120);
`ifdef DIST_MIN_EARLY_STOP_EN
    chk("t5_done1", 64'(bus.done), 64'd1);
`else
    chk("t5_done1", 64'(bus.done), 64'd0);
`endif
    feed(90, 3); feed(80, 4); quiet();
`ifdef DIST_MIN_EARLY_STOP_EN
    chk("t5_best",  64'(bus.best_dist), 64'd120);
    chk("t5_count", 64'(bus.cand_count), 64'd2);
`else
    chk("t5_best",  64'(bus.best_dist), 64'd80);
    chk("t5_count", 64'(bus.cand_count), 64'd4);
`endif
    chk("t5_done", 64'(bus.done), 64'd1);
    chk("t5_hit",  64'(bus.hit), 64'd1);

    // All-ones distance still becomes the first best; dist equal to thresh hits
    start(2, 38'd77);
    feed(ALL1, 5); quiet();
    chk("t6_valid", 64'(bus.best_valid), 64'd1);
    chk("t6_id",    64'(bus.best_id), 64'd5);
    feed(77, 6); quiet();
    chk("t6_hit",   64'(bus.hit), 64'd1);
    chk("t6_best",  64'(bus.best_dist), 64'd77);

    // Reset mid-search
    start(3, 0);
    feed(50, 1);
    reset = 1'b1; quiet();
    @(negedge clk);
    reset = 1'b0;
    chk("t7_busy",  64'(bus.busy), 64'd0);
    chk("t7_valid", 64'(bus.best_valid), 64'd0);
    chk("t7_best",  64'(bus.best_dist), 64'(ALL1));
    feed(7, 7); quiet();
    chk("t7_count", 64'(bus.cand_count), 64'd0);
    chk("t7_done",  64'(bus.done), 64'd0);
    @(negedge clk);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dist_min_tracker.md
Name: dist_min_tracker

Overview:
- Sits directly downstream of the matrix distance calculator.
- Consumes one squared-distance result per candidate gate sequence and tracks the minimum distance and the id of the candidate that produced it.
- Reports completion when the expected number of candidates has been scored, or optionally early when a candidate falls within a threshold.
- Its outputs feed the compiler's search controller.

Parameters:
- DIST_W, 38: width of the unsigned squared-distance input (matches the calculator's dist2).
- ID_W, 16: width of candidate ids and of the candidate count.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- search_start  input  1  one-cycle pulse; begins or restarts a search.
- n_cand  input  ID_W  number of candidates expected; sampled on search_start.
- thresh  input  DIST_W  acceptance threshold; sampled on search_start.
- dist_valid  input  1  dist2/cand_id valid this cycle; the calculator's finished, id-aligned upstream.
- dist2  input  DIST_W  squared distance, unsigned.
- cand_id  input  ID_W  id of the scored candidate.
- busy  output  1  high in SEARCH.
- done  output  1  high (level) in DONE.
- best_valid  output  1  at least one candidate scored this search.
- best_dist  output  DIST_W  minimum distance so far.
- best_id  output  ID_W  id of best_dist.
- cand_count  output  ID_W  candidates scored this search.
- hit  output  1  some candidate had dist2 <= thresh.

Behaviour:
- Reset values: state IDLE; busy=0, done=0, best_valid=0, best_dist=all ones, best_id=0, cand_count=0, hit=0. Latched n_cand and thresh are cleared to 0.
- States: IDLE, SEARCH, DONE.
- search_start in any state:
  - Next cycle: best_dist=all ones, best_id=0, best_valid=0, cand_count=0, hit=0.
  - n_cand and thresh are latched.
  - State becomes SEARCH, or DONE directly if n_cand==0.
- Start beats data: a search_start coincident with dist_valid discards that sample.
- IDLE/DONE: dist_valid is ignored and all outputs hold. DONE holds until the next search_start or reset.
- SEARCH, on dist_valid:
  - cand_count += 1.
  - If dist2 < best_dist (strict) or best_valid==0: best_dist=dist2, best_id=cand_id, best_valid=1.
  - Ties keep the earlier candidate.
  - If dist2 <= latched thresh, hit=1 (sticky until next start).
  - If cand_count+1 == latched n_cand, next state is DONE.
- Latency: every update is visible on the cycle after dist_valid. done rises on the cycle after the final sample.
- Comparisons are unsigned, full DIST_W width; no saturation needed.
- cand_count cannot wrap, because the transition to DONE occurs at n_cand <= 2^ID_W-1.
- dist2 == all ones is still accepted as the first best (via best_valid==0).
- reset mid-search aborts immediately to the reset values.

Optional Feature:
- Macro: DIST_MIN_EARLY_STOP_EN.
- Defined: a SEARCH sample with dist2 <= latched thresh performs the normal update, then moves to DONE next cycle regardless of cand_count. Later dist_valid pulses are ignored.
- Undefined: hit is still reported, but the search always runs until n_cand samples have been scored.

Decomposition:
- Shared package (dist_pkg) holds:
  - DIST_W and ID_W defaults.
  - State enum typedef {IDLE, SEARCH, DONE}.
  - dist_t and cand_id_t typedefs.
  - DIST_MAX constant (all ones).
- One natural sub-module, dist_min_cmp: combinational compare/select of incoming vs. best. Outputs take_new and within_thresh.
- FSM and registers stay in the top.

Test Plan:
- Reset, then search_start with n_cand=3, thresh=0. Feed (dist 500, id 7), (200, id 9), (300, id 4) on consecutive cycles -> best_dist=200, best_id=9, cand_count=3, done=1 one cycle after the third sample; hit=0.
- Tie: n_cand=2, feed (100, id 1) then (100, id 2) -> best_id=1.
- n_cand=0 start -> done=1 the next cycle; best_valid=0, best_dist=all ones.
- search_start coincident with dist_valid (dist 5) during SEARCH -> sample discarded; cand_count=0 and best_valid=0 next cycle.
- thresh=150, n_cand=4, feed 400, 120, 90, 80:
  - With DIST_MIN_EARLY_STOP_EN: done the cycle after 120; best_dist=120, cand_count=2, hit=1.
  - Without the macro: done after the 4th sample; best_dist=80, hit=1.
- reset asserted after 1 of 3 samples -> all outputs at reset values next cycle; later dist_valid ignored until search_start.
